// File: rtl/uart_rx_apb_pkg.sv
// rtl/uart_rx_apb_pkg.sv - register map, error codes and FSM enums for the UART RX APB poller
package uart_rx_apb_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_ERROR  = 3'd1;
    localparam logic [2:0] ADDR_BP0    = 3'd2;
    localparam logic [2:0] ADDR_BP1    = 3'd3;
    localparam logic [2:0] ADDR_DSIZE  = 3'd4;
    localparam logic [2:0] ADDR_DATA   = 3'd6;

    localparam logic [7:0] ERR_FRAMING = 8'h01;
    localparam logic [7:0] ERR_OVERRUN = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP
    } state_e;

    typedef enum logic [2:0] {
        OP_WR_BP0,
        OP_WR_BP1,
        OP_WR_DS,
        OP_RD_STAT,
        OP_RD_ERR,
        OP_RD_DATA
    } op_e;

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// rtl/uart_rx_byte_fifo.sv - first-word-fall-through byte FIFO, power-of-two depth
module uart_rx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? 8'h00 : mem_q[rptr_q];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (do_pop) rptr_q <= rptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_apb_poller.sv
// rtl/uart_rx_apb_poller.sv - APB master that configures the UART RX and drains bytes into a FIFO
// UART_RX_POLL_ERR_EN: read the error register per byte, keep sticky err_flags, drop errored bytes.
module uart_rx_apb_poller
    import uart_rx_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        enable,
    input  logic [13:0] cfg_bit_period,
    input  logic [3:0]  cfg_data_size,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [2:0]  paddr,
    output logic [7:0]  pwdata,
    input  logic [7:0]  prdata,
    input  logic        pslverr,
    output logic [7:0]  fifo_rdata,
    output logic        fifo_empty,
    input  logic        fifo_pop,
    output logic        busy,
    output logic        cfg_done,
    output logic        slverr_flag,
    output logic [1:0]  err_flags
);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = 1;
    localparam logic [$clog2(FIFO_DEPTH):0] FIFO_CAP = ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [13:0]   bp_q, bp_d;
    logic [3:0]    ds_q, ds_d;
    logic          cfg_done_q, cfg_done_d;
    logic          slverr_q, slverr_d;
    logic [1:0]    err_q, err_d;
    logic          drop_q, drop_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          push_req;
    logic          fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push_req && !fifo_full),
        .wdata (prdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy        = (state_q != ST_IDLE);
    assign cfg_done    = cfg_done_q;
    assign slverr_flag = slverr_q;
    assign err_flags   = err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WR_BP0;
            bp_q       <= '0;
            ds_q       <= '0;
            cfg_done_q <= 1'b0;
            slverr_q   <= 1'b0;
            err_q      <= '0;
            drop_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bp_q       <= bp_d;
            ds_q       <= ds_d;
            cfg_done_q <= cfg_done_d;
            slverr_q   <= slverr_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bp_d       = bp_q;
        ds_d       = ds_q;
        cfg_done_d = cfg_done_q;
        slverr_d   = slverr_q;
        err_d      = err_q;
        drop_d     = drop_q;
        gap_d      = '0;
        push_req   = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = 3'd0;
        pwdata     = 8'h00;

        // Bus lines are only driven during a transfer so idle/reset shows all zeros.
        if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
            psel    = 1'b1;
            penable = (state_q == ST_ACCESS);
            case (op_q)
                OP_WR_BP0:  begin pwrite = 1'b1; paddr = ADDR_BP0;   pwdata = bp_q[7:0]; end
                OP_WR_BP1:  begin pwrite = 1'b1; paddr = ADDR_BP1;   pwdata = {2'b00, bp_q[13:8]}; end
                OP_WR_DS:   begin pwrite = 1'b1; paddr = ADDR_DSIZE; pwdata = {4'h0, ds_q}; end
                OP_RD_STAT: paddr = ADDR_STATUS;
                OP_RD_ERR:  paddr = ADDR_ERROR;
                default:    paddr = ADDR_DATA;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bp_d       = cfg_bit_period;
                    ds_d       = cfg_data_size;
                    cfg_done_d = 1'b0;
                    slverr_d   = 1'b0;
                    err_d      = '0;
                    op_d       = OP_WR_BP0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pslverr) begin
                    slverr_d = 1'b1;
                    state_d  = pwrite ? ST_IDLE : ST_GAP;
                end else begin
                    case (op_q)
                        OP_WR_BP0: begin op_d = OP_WR_BP1; state_d = ST_SETUP; end
                        OP_WR_BP1: begin op_d = OP_WR_DS;  state_d = ST_SETUP; end
                        OP_WR_DS: begin
                            cfg_done_d = 1'b1;
                            state_d    = ST_GAP;
                        end
                        OP_RD_STAT: begin
                            if (prdata[0]) begin
                                drop_d  = 1'b0;
`ifdef UART_RX_POLL_ERR_EN
                                op_d    = OP_RD_ERR;
`else
                                op_d    = OP_RD_DATA;
`endif
                                state_d = ST_SETUP;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end
                        OP_RD_ERR: begin
                            err_d   = err_q | {|(prdata & ERR_OVERRUN), |(prdata & ERR_FRAMING)};
                            drop_d  = |prdata;
                            op_d    = OP_RD_DATA;
                            state_d = ST_SETUP;
                        end
                        default: begin
                            push_req = !drop_q;
                            state_d  = ST_GAP;
                        end
                    endcase
                end
            end
            default: begin
                // Counter saturates at GAP_LAST so a full FIFO simply holds here.
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + GAP_ONE;
                end else begin
                    gap_d = gap_q;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (fifo_count < FIFO_CAP) begin
                        op_d    = OP_RD_STAT;
                        state_d = ST_SETUP;
                    end
                end
            end
        endcase
    end

endmodule
